character2_motion_ctrl: RTL
===========================

// Module: character2_motion_ctrl
// PURPOSE
//  Per-frame motion sequencer for the player-2 sprite. Samples player controls once per frame
//  and runs a walk/jump/gravity state machine. Produces the registered CharX/CharY origin that
//  drives the character2 sprite renderer. Sits between keyboard decode and the sprite draw
//  path, in the vga_clk domain.
// PARAMETERS
//  CHAR_WIDTH  40   sprite width (px); horizontal clamp uses it
//  X_MIN       0    leftmost legal CharX
//  X_MAX       640  right screen edge; max CharX = X_MAX-CHAR_WIDTH (600)
//  Y_MIN       0    topmost legal CharY
//  GROUND_Y    380  CharY when standing
//  START_X     500  spawn/reset CharX
//  WALK_STEP   2    px per frame while walking
//  JUMP_VEL    12   initial upward speed (px/frame)
//  GRAVITY     1    vy increment per frame while airborne
//  MAX_FALL    12   vy saturation (downward)
// PORTS
//  vga_clk     in   1   pixel clock, all state rising-edge
//  reset_n     in   1   async active-low reset
//  vsync       in   1   VGA vsync (active low); its falling edge = frame tick
//  key_left    in   1   move left (level)
//  key_right   in   1   move right (level)
//  key_jump    in   1   jump (level; edge-detected at ticks)
//  freeze      in   1   hold all motion (goal celebration/pause)
//  spawn       in   1   1-cycle pulse: return to spawn point
//  CharX       out  10  sprite origin X (registered)
//  CharY       out  10  sprite origin Y (registered)
//  vel_y       out  6   signed vertical velocity, +down
//  state       out  2   0 GROUNDED, 1 RISING, 2 FALLING
//  facing_left out  1   last horizontal direction
// BEHAVIOUR
//  - Reset (async, reset_n=0): CharX=START_X, CharY=GROUND_Y, vel_y=0, state=GROUNDED,
//    facing_left=1, vs_q=1, jump_prev=0, dj_used=0.
//  - tick = vs_q & ~vsync; vs_q <= vsync every cycle. All motion updates on the edge where
//    tick=1 -> outputs change 1 cycle after vsync falls. Exactly one update per frame.
//  - Priority per cycle: spawn > freeze > tick. spawn: load reset values (vs_q untouched).
//    freeze=1: tick ignored, but jump_prev still updated (no stale jump edge on unfreeze).
//  - jump_edge = key_jump & ~jump_prev; jump_prev <= key_jump at every tick.
//  - Horizontal (any state): left only -> x-=WALK_STEP, facing_left=1; right only ->
//    x+=WALK_STEP, facing_left=0; both/neither -> no move, facing kept. Compute in signed 11b,
//    clamp to [X_MIN, X_MAX-CHAR_WIDTH].
//  - GROUNDED: jump_edge -> vel_y=-JUMP_VEL, state=RISING, CharY unchanged this tick.
//  - RISING/FALLING: y_n = CharY + vel_y (signed 11b); vel_y <= min(vel_y+GRAVITY, MAX_FALL).
//    y_n >= GROUND_Y -> CharY=GROUND_Y, vel_y=0, GROUNDED, dj_used=0 (landing).
//    y_n < Y_MIN -> CharY=Y_MIN, vel_y=0, FALLING (head clamp).
//    else CharY=y_n; state = (new vel_y<0) ? RISING : FALLING.
//  - Walking and gravity apply in same tick; landing and horizontal clamp independent.
// CONFIGURATION
//  CHAR2_DOUBLE_JUMP_EN defined: in RISING/FALLING with dj_used=0, jump_edge -> vel_y=-JUMP_VEL,
//   state=RISING, dj_used=1, CharY unchanged this tick (replaces gravity step).
//   dj_used clears on landing/spawn/reset.
//  Undefined: airborne jump_edge ignored; dj_used logic absent (tie 0).
// TESTING
//  1 reset_n low mid-frame -> CharX=500, CharY=380, state=0, facing_left=1 immediately.
//  2 key_right held 3 ticks -> CharX 506, facing_left=0; both keys held -> CharX unchanged.
//  3 CharX=598, key_right 2 ticks -> 600 then 600; CharX=1, key_left -> 0.
//  4 jump pulse at tick 1 -> vel_y=-12, CharY=380, RISING; tick 2 CharY=368, vel_y=-11;
//    tick 13 CharY=302, vel_y=0, FALLING; tick 26 CharY=380, GROUNDED; key_jump held no rejump.
//  5 spawn and tick same cycle mid-air -> spawn values; freeze held 5 ticks -> no change.
//  6 CHAR2_DOUBLE_JUMP_EN: 2nd jump edge at tick 5 -> vel_y=-12, CharY held; 3rd edge
//    ignored; undefined build: 2nd edge ignored, trajectory as scenario 4.

Source files
------------

// File: rtl/character2_motion_ctrl.sv
// rtl/character2_motion_ctrl.sv - per-frame walk/jump/gravity sequencer for the player-2 sprite
// Optional airborne double jump enabled by defining CHAR2_DOUBLE_JUMP_EN.
module character2_motion_ctrl #(
    parameter int CHAR_WIDTH = 40,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 640,
    parameter int Y_MIN      = 0,
    parameter int GROUND_Y   = 380,
    parameter int START_X    = 500,
    parameter int WALK_STEP  = 2,
    parameter int JUMP_VEL   = 12,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 12
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              vsync,
    input  logic              key_left,
    input  logic              key_right,
    input  logic              key_jump,
    input  logic              freeze,
    input  logic              spawn,
    output logic [9:0]        CharX,
    output logic [9:0]        CharY,
    output logic signed [5:0] vel_y,
    output logic [1:0]        state,
    output logic              facing_left
);

    typedef enum logic [1:0] {
        ST_GROUNDED = 2'd0,
        ST_RISING   = 2'd1,
        ST_FALLING  = 2'd2
    } state_t;

    localparam logic signed [10:0] L_STEP   = 11'(WALK_STEP);
    localparam logic signed [10:0] L_X_LO   = 11'(X_MIN);
    localparam logic signed [10:0] L_X_HI   = 11'(X_MAX - CHAR_WIDTH);
    localparam logic signed [10:0] L_Y_LO   = 11'(Y_MIN);
    localparam logic signed [10:0] L_GROUND = 11'(GROUND_Y);
    localparam logic signed [5:0]  L_JUMP   = 6'(-JUMP_VEL);
    localparam logic signed [5:0]  L_GRAV   = 6'(GRAVITY);
    localparam logic signed [5:0]  L_MAXF   = 6'(MAX_FALL);

    state_t            r_state, w_state_nxt;
    logic [9:0]        r_x, r_y, w_x_nxt, w_y_nxt;
    logic signed [5:0] r_vel, w_vel_nxt, w_vel_inc;
    logic              r_facing, w_facing_nxt;
    logic              r_vs_q, r_jump_prev, w_jump_prev_nxt;
    logic              w_tick, w_jump_edge, w_dj_nxt, w_dj_avail;
    logic signed [10:0] w_x_calc, w_y_calc;

`ifdef CHAR2_DOUBLE_JUMP_EN
    logic r_dj_used;
    assign w_dj_avail = ~r_dj_used;
`else
    assign w_dj_avail = 1'b0;
`endif

    assign w_tick      = r_vs_q & ~vsync;
    assign w_jump_edge = key_jump & ~r_jump_prev;
    assign w_vel_inc   = (r_vel + L_GRAV > L_MAXF) ? L_MAXF : r_vel + L_GRAV;
    assign w_y_calc    = $signed({1'b0, r_y}) + {{5{r_vel[5]}}, r_vel};

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_GROUNDED;
            r_x         <= 10'(START_X);
            r_y         <= 10'(GROUND_Y);
            r_vel       <= '0;
            r_facing    <= 1'b1;
            r_vs_q      <= 1'b1;
            r_jump_prev <= 1'b0;
`ifdef CHAR2_DOUBLE_JUMP_EN
            r_dj_used   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_vel       <= w_vel_nxt;
            r_facing    <= w_facing_nxt;
            r_vs_q      <= vsync;
            r_jump_prev <= w_jump_prev_nxt;
`ifdef CHAR2_DOUBLE_JUMP_EN
            r_dj_used   <= w_dj_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_vel_nxt       = r_vel;
        w_facing_nxt    = r_facing;
        w_jump_prev_nxt = r_jump_prev;
        w_dj_nxt        = ~w_dj_avail;
        w_x_calc        = $signed({1'b0, r_x});
        if (spawn) begin
            w_state_nxt     = ST_GROUNDED;
            w_x_nxt         = 10'(START_X);
            w_y_nxt         = 10'(GROUND_Y);
            w_vel_nxt       = '0;
            w_facing_nxt    = 1'b1;
            w_jump_prev_nxt = 1'b0;
            w_dj_nxt        = 1'b0;
        end else if (freeze) begin
            // Track the key while paused so releasing freeze never fires a stale jump.
            if (w_tick) w_jump_prev_nxt = key_jump;
        end else if (w_tick) begin
            w_jump_prev_nxt = key_jump;
            if (key_left && !key_right) begin
                w_x_calc     = $signed({1'b0, r_x}) - L_STEP;
                w_facing_nxt = 1'b1;
            end else if (key_right && !key_left) begin
                w_x_calc     = $signed({1'b0, r_x}) + L_STEP;
                w_facing_nxt = 1'b0;
            end
            if (w_x_calc < L_X_LO)      w_x_nxt = L_X_LO[9:0];
            else if (w_x_calc > L_X_HI) w_x_nxt = L_X_HI[9:0];
            else                        w_x_nxt = w_x_calc[9:0];

            if (r_state == ST_GROUNDED) begin
                if (w_jump_edge) begin
                    w_vel_nxt   = L_JUMP;
                    w_state_nxt = ST_RISING;
                end
            end else if (w_jump_edge && w_dj_avail) begin
                w_vel_nxt   = L_JUMP;
                w_state_nxt = ST_RISING;
                w_dj_nxt    = 1'b1;
            end else if (w_y_calc >= L_GROUND) begin
                w_y_nxt     = L_GROUND[9:0];
                w_vel_nxt   = '0;
                w_state_nxt = ST_GROUNDED;
                w_dj_nxt    = 1'b0;
            end else if (w_y_calc < L_Y_LO) begin
                w_y_nxt     = L_Y_LO[9:0];
                w_vel_nxt   = '0;
                w_state_nxt = ST_FALLING;
            end else begin
                w_y_nxt     = w_y_calc[9:0];
                w_vel_nxt   = w_vel_inc;
                w_state_nxt = w_vel_inc[5] ? ST_RISING : ST_FALLING;
            end
        end
    end

    assign CharX       = r_x;
    assign CharY       = r_y;
    assign vel_y       = r_vel;
    assign state       = r_state;
    assign facing_left = r_facing;

endmodule
